audio_dac_serializer: RTL and testbench

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

---
 rtl/audio_pkg.sv | 21 ++
 rtl/audio_sample_fifo.sv | 76 +++++++
 rtl/audio_dac_serializer.sv | 144 ++++++++++++++
 tb/tb_audio_dac_serializer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the I2S audio DAC serializer: default geometry,
// I2S framing constant, stereo sample pair type and serializer states.
package audio_pkg;

  localparam int AUDIO_DATA_WIDTH = 24;
  localparam int AUDIO_FIFO_DEPTH = 8;
  // I2S places the MSB one bit clock after the LRCK transition.
  localparam int AUDIO_I2S_DELAY  = 1;

  typedef struct packed {
    logic [AUDIO_DATA_WIDTH-1:0] left;
    logic [AUDIO_DATA_WIDTH-1:0] right;
  } stereo_pair_t;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_LEFT  = 2'd1,
    SER_RIGHT = 2'd2
  } ser_state_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous first-word-fall-through FIFO holding packed stereo pairs.
// Occupancy, empty and ready are registered so they can leave the block
// directly as outputs.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 2 * AUDIO_DATA_WIDTH,
  parameter int DEPTH = AUDIO_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             ready,
  output logic [LW-1:0]    level
);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_next;

  assign rd_data = mem[rd_ptr];

  // Qualify requests against current state and compute next occupancy
  always_comb begin
    do_push    = push && ready;
    do_pop     = pop && !empty;
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + LW'(1);
    end else if (do_pop && !do_push) begin
      level_next = level - LW'(1);
    end else begin
      level_next = level;
    end
  end

  // Pointer and status registers; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      level  <= {LW{1'b0}};
      empty  <= 1'b1;
      ready  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
      empty <= (level_next == {LW{1'b0}});
      ready <= (level_next != LEVEL_FULL);
    end
  end

  // Sample storage; no reset needed because the pointers gate every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: buffers stereo pairs in a FIFO and shifts them out
// MSB first on DACDAT, timed by codec-supplied BCLK/DACLRCK which are
// asynchronous to clk_clk and oversampled through synchronizers.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [DATA_WIDTH-1:0]       left_data,
  input  logic [DATA_WIDTH-1:0]       right_data,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic                        BCLK,
  input  logic                        DACLRCK,
  output logic                        DACDAT,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  // Counter value meaning "word fully shifted, emit padding".
  localparam logic [CW-1:0] CNT_IDLE = CW'(DATA_WIDTH);

  logic                    bclk_meta;
  logic                    bclk_sync;
  logic                    bclk_last;
  logic                    lrck_meta;
  logic                    lrck_sync;
  logic                    lrck_prev;

  logic                    bclk_fall;
  logic                    left_start;
  logic                    right_start;

  logic                    fifo_pop;
  logic                    fifo_empty;
  logic [2*DATA_WIDTH-1:0] fifo_rd_data;
  logic [DATA_WIDTH-1:0]   pop_left;
  logic [DATA_WIDTH-1:0]   pop_right;

  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   hold_reg;
  logic [CW-1:0]           bit_cnt;
  ser_state_e              state;

  assign pop_left  = fifo_rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign pop_right = fifo_rd_data[DATA_WIDTH-1:0];

  audio_sample_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .reset   (reset_reset),
    .push    (sample_valid),
    .wr_data ({left_data, right_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .ready   (sample_ready),
    .level   (fifo_level)
  );

  // Two-flop synchronizers plus one extra BCLK stage for fall detection
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      bclk_meta <= 1'b0;
      bclk_sync <= 1'b0;
      bclk_last <= 1'b0;
      lrck_meta <= 1'b0;
      lrck_sync <= 1'b0;
    end else begin
      bclk_meta <= BCLK;
      bclk_sync <= bclk_meta;
      bclk_last <= bclk_sync;
      lrck_meta <= DACLRCK;
      lrck_sync <= lrck_meta;
    end
  end

  // Decode bit-clock falls and frame transitions; pop only on a left start
  always_comb begin
    bclk_fall   = bclk_last && !bclk_sync;
    left_start  = bclk_fall && lrck_prev && !lrck_sync;
    right_start = bclk_fall && !lrck_prev && lrck_sync;
    fifo_pop    = left_start && !fifo_empty;
  end

  // Serializer FSM: loads words at LRCK edges and shifts one bit per BCLK fall
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= SER_IDLE;
      shift_reg <= {DATA_WIDTH{1'b0}};
      hold_reg  <= {DATA_WIDTH{1'b0}};
      bit_cnt   <= CNT_IDLE;
      lrck_prev <= 1'b0;
      DACDAT    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (bclk_fall) begin
        lrck_prev <= lrck_sync;
        case ({left_start, right_start})
          2'b10: begin
            state   <= SER_LEFT;
            bit_cnt <= {CW{1'b0}};
            DACDAT  <= 1'b0;
            if (!fifo_empty) begin
              shift_reg <= pop_left;
              hold_reg  <= pop_right;
            end else begin
              shift_reg <= {DATA_WIDTH{1'b0}};
              hold_reg  <= {DATA_WIDTH{1'b0}};
              underrun  <= 1'b1;
            end
          end
          2'b01: begin
            state   <= SER_RIGHT;
            bit_cnt <= {CW{1'b0}};
            DACDAT  <= 1'b0;
            // A right word is only valid if its left half went out this frame.
            case (state)
              SER_LEFT: shift_reg <= hold_reg;
              default:  shift_reg <= {DATA_WIDTH{1'b0}};
            endcase
          end
          default: begin
            if (bit_cnt < CNT_IDLE) begin
              DACDAT    <= shift_reg[DATA_WIDTH-1];
              shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
              bit_cnt   <= bit_cnt + CW'(1);
            end else begin
              DACDAT <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer: a BCLK/LRCK generator models
// the codec and the FIFO pop decision, a monitor decodes DACDAT at BCLK rises
// and compares each frame against the scoreboard.
module tb_audio_dac_serializer;
  import audio_pkg::*;

  localparam int DW = AUDIO_DATA_WIDTH;
  localparam int FD = AUDIO_FIFO_DEPTH;
  localparam int LW = $clog2(FD) + 1;

  logic          clk_clk;
  logic          reset_reset;
  logic [DW-1:0] left_data;
  logic [DW-1:0] right_data;
  logic          sample_valid;
  logic          sample_ready;
  logic          BCLK;
  logic          DACLRCK;
  logic          DACDAT;
  logic          underrun;
  logic [LW-1:0] fifo_level;

  int vectors     = 0;
  int miscompares = 0;

  stereo_pair_t sb_q[$];
  stereo_pair_t frame_q[$];
  int  ur_exp       = 0;
  int  ur_seen      = 0;
  int  gen_req      = 0;
  bit  gen_busy     = 1'b0;
  bit  gen_in_frame = 1'b0;
  int  bit_pos      = 0;
  int  left_starts  = 0;
  time left_fall_time = 0;
  bit  discard_frame  = 1'b0;

  audio_dac_serializer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .BCLK         (BCLK),
    .DACLRCK      (DACLRCK),
    .DACDAT       (DACDAT),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  initial begin
    clk_clk = 1'b0;
    forever #5 clk_clk = ~clk_clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic stereo_pair_t mk(input logic [DW-1:0] l, input logic [DW-1:0] r);
    stereo_pair_t p;
    p.left  = l;
    p.right = r;
    return p;
  endfunction

  // Codec model: BCLK = clk/16, 32 BCLK per half frame, LRCK changes on BCLK fall.
  // The FIFO pop is modelled two clk edges after the fall, where the DUT's
  // pre-push FIFO state matches the pushes recorded so far.
  initial begin : codec_gen
    stereo_pair_t zp;
    zp = '0;
    BCLK    = 1'b1;
    DACLRCK = 1'b1;
    forever begin
      @(negedge clk_clk);
      if (gen_req > 0) begin
        int nf;
        nf       = gen_req;
        gen_req  = 0;
        gen_busy = 1'b1;
        gen_in_frame = 1'b0;
        repeat (4) begin
          BCLK = 1'b0;
          repeat (8) @(negedge clk_clk);
          BCLK = 1'b1;
          repeat (8) @(negedge clk_clk);
        end
        for (int f = 0; f < nf; f++) begin
          for (int p = 0; p < 64; p++) begin
            BCLK    = 1'b0;
            DACLRCK = (p >= 32);
            bit_pos = p;
            gen_in_frame = 1'b1;
            if (p == 0) begin
              left_fall_time = $time;
              left_starts++;
              @(posedge clk_clk);
              @(posedge clk_clk);
              if (sb_q.size() > 0) begin
                frame_q.push_back(sb_q.pop_front());
              end else begin
                frame_q.push_back(zp);
                ur_exp++;
              end
              repeat (7) @(negedge clk_clk);
            end else begin
              repeat (8) @(negedge clk_clk);
            end
            BCLK = 1'b1;
            repeat (8) @(negedge clk_clk);
          end
        end
        gen_in_frame = 1'b0;
        gen_busy     = 1'b0;
      end
    end
  end

  // Decode DACDAT at BCLK rises and compare each complete frame
  initial begin : monitor
    logic [DW-1:0] word;
    logic [DW-1:0] lword;
    bit            pad_ok;
    int            hp;
    stereo_pair_t  exp;
    word   = '0;
    lword  = '0;
    pad_ok = 1'b1;
    forever begin
      @(posedge BCLK);
      if (gen_in_frame) begin
        hp = bit_pos % 32;
        if (bit_pos == 0) pad_ok = 1'b1;
        if (hp == 0) word = '0;
        if (hp >= AUDIO_I2S_DELAY && hp < AUDIO_I2S_DELAY + DW)
          word = {word[DW-2:0], DACDAT};
        else
          pad_ok = pad_ok && (DACDAT === 1'b0);
        if (bit_pos == 31) lword = word;
        if (bit_pos == 63) begin
          if (discard_frame) begin
            discard_frame = 1'b0;
          end else begin
            check("frame_expected", 64'(frame_q.size() > 0), 64'd1);
            if (frame_q.size() > 0) begin
              exp = frame_q.pop_front();
              check("left_word", 64'(lword), 64'(exp.left));
              check("right_word", 64'(word), 64'(exp.right));
              check("slot_and_pad", 64'(pad_ok), 64'd1);
            end
          end
        end
      end
    end
  end

  // Count clk cycles in which underrun is high
  always @(negedge clk_clk) begin
    if (underrun === 1'b1) ur_seen++;
  end

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int guard;
    guard = 0;
    @(negedge clk_clk);
    while (sample_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk_clk);
      guard++;
    end
    check("push_ready", 64'(sample_ready), 64'd1);
    sample_valid = 1'b1;
    left_data    = l;
    right_data   = r;
    sb_q.push_back(mk(l, r));
    @(negedge clk_clk);
    sample_valid = 1'b0;
  endtask

  task automatic start_frames(input int n);
    int guard;
    guard   = 0;
    gen_req = n;
    while (!gen_busy && guard < 100) begin
      @(negedge clk_clk);
      guard++;
    end
    check("gen_start", 64'(gen_busy), 64'd1);
  endtask

  task automatic wait_frames();
    int guard;
    guard = 0;
    while (gen_busy && guard < 40000) begin
      @(negedge clk_clk);
      guard++;
    end
    check("gen_done", 64'(gen_busy), 64'd0);
  endtask

  initial begin : main
    int            ur0;
    int            guard;
    int            ls0;
    logic [DW-1:0] lv;
    logic [DW-1:0] rv;

    reset_reset  = 1'b1;
    sample_valid = 1'b0;
    left_data    = '0;
    right_data   = '0;
    repeat (4) @(negedge clk_clk);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    check("rst_dacdat", 64'(DACDAT), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ready", 64'(sample_ready), 64'd1);

    // One pair, one frame: delay slot, A5A5A5 / 3C3C3C MSB first, padding
    push_pair(24'hA5A5A5, 24'h3C3C3C);
    check("level_one", 64'(fifo_level), 64'd1);
    start_frames(1);
    wait_frames();
    check("underrun_none_a", 64'(ur_seen), 64'(ur_exp));

    // Empty FIFO for two frames: silence and one underrun per left start
    ur0 = ur_seen;
    start_frames(2);
    wait_frames();
    check("underrun_two", 64'(ur_seen - ur0), 64'd2);
    check("underrun_model_b", 64'(ur_seen), 64'(ur_exp));

    // Fill with BCLK stopped: 9 back-to-back pairs, 9th held off
    @(negedge clk_clk);
    for (int i = 0; i < 9; i++) begin
      check("ready_fill", 64'(sample_ready), 64'(sb_q.size() != FD));
      lv = DW'(32'h100000 + i);
      rv = DW'(32'h200000 + i);
      sample_valid = 1'b1;
      left_data    = lv;
      right_data   = rv;
      if (sample_ready === 1'b1) sb_q.push_back(mk(lv, rv));
      @(negedge clk_clk);
    end
    check("full_level", 64'(fifo_level), 64'(FD));
    check("full_ready", 64'(sample_ready), 64'd0);
    repeat (5) @(negedge clk_clk);
    check("full_hold_level", 64'(fifo_level), 64'(FD));
    start_frames(9);
    guard = 0;
    while (sample_ready !== 1'b1 && guard < 5000) begin
      @(negedge clk_clk);
      guard++;
    end
    check("ninth_ready", 64'(sample_ready), 64'd1);
    sb_q.push_back(mk(lv, rv));
    @(negedge clk_clk);
    sample_valid = 1'b0;
    wait_frames();
    check("drain_level", 64'(fifo_level), 64'd0);
    check("underrun_model_c", 64'(ur_seen), 64'(ur_exp));

    // Push in the very cycle of an empty-FIFO left start
    ls0 = left_starts;
    start_frames(2);
    guard = 0;
    while (left_starts == ls0 && guard < 2000) begin
      @(negedge clk_clk);
      guard++;
    end
    check("left_start_seen", 64'(left_starts != ls0), 64'd1);
    while ($time < left_fall_time + 20) @(negedge clk_clk);
    sample_valid = 1'b1;
    left_data    = 24'h123456;
    right_data   = 24'hFEDCBA;
    sb_q.push_back(mk(24'h123456, 24'hFEDCBA));
    @(negedge clk_clk);
    sample_valid = 1'b0;
    check("same_cycle_underrun", 64'(underrun), 64'd1);
    check("same_cycle_level", 64'(fifo_level), 64'd1);
    wait_frames();
    check("underrun_model_d", 64'(ur_seen), 64'(ur_exp));

    // Reset at bit 10 of a left word with 3 pairs still queued
    for (int i = 0; i < 4; i++) push_pair(DW'(32'h0ABC00 + i), DW'(32'h0DEF00 + i));
    start_frames(2);
    guard = 0;
    while (!(gen_in_frame && bit_pos == 11) && guard < 5000) begin
      @(negedge clk_clk);
      guard++;
    end
    check("reached_bit10", 64'(bit_pos), 64'd11);
    check("queued_three", 64'(fifo_level), 64'd3);
    reset_reset = 1'b1;
    sb_q.delete();
    frame_q.delete();
    discard_frame = 1'b1;
    @(negedge clk_clk);
    check("midreset_dacdat", 64'(DACDAT), 64'd0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    check("midreset_level", 64'(fifo_level), 64'd0);
    check("midreset_ready", 64'(sample_ready), 64'd1);
    check("midreset_dacdat_after", 64'(DACDAT), 64'd0);
    push_pair(24'h5A5A5A, 24'h0F0F0F);
    wait_frames();
    check("underrun_model_e", 64'(ur_seen), 64'(ur_exp));

    // Stream 20 pairs 1..20 without underrun
    ur0 = ur_seen;
    for (int i = 1; i <= FD; i++) push_pair(DW'(i), DW'(i) ^ 24'hFFFFFF);
    start_frames(20);
    for (int i = FD + 1; i <= 20; i++) push_pair(DW'(i), DW'(i) ^ 24'hFFFFFF);
    wait_frames();
    check("stream_no_underrun", 64'(ur_seen - ur0), 64'd0);
    check("stream_level", 64'(fifo_level), 64'd0);
    check("stream_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
